// File: rtl/flash_program_seq_if.sv
// Bus between the program sequencer (master) and the flash_b controller (slave).
// Handshake: fl_erase/fl_write/fl_read_cmd are one-cycle request strobes qualified by fl_addr/fl_length.
// The master raises one only while flash_b is idle, and fl_done is the single-cycle completion acknowledge.
// fl_rd/fl_wr are per-byte valid strobes from flash_b with no back-pressure.
interface flash_program_seq_if;
  logic        fl_erase;
  logic        fl_write;
  logic        fl_read_cmd;
  logic [31:0] fl_addr;
  logic [31:0] fl_length;
  logic [7:0]  fl_din;
  logic [7:0]  fl_dout;
  logic        fl_rd;
  logic        fl_wr;
  logic        fl_done;

  modport master (
    output fl_erase, fl_write, fl_read_cmd, fl_addr, fl_length, fl_din,
    input  fl_dout, fl_rd, fl_wr, fl_done
  );

  modport slave (
    input  fl_erase, fl_write, fl_read_cmd, fl_addr, fl_length, fl_din,
    output fl_dout, fl_rd, fl_wr, fl_done
  );
endinterface

// File: rtl/flash_program_seq.sv
// Drives flash_b through erase, page-program and optional read-back verify for one job,
// checksumming written and read-back bytes and reporting an error code.
module flash_program_seq #(
  parameter int unsigned PAGES_LOG2_PER_SECTOR = 8,
  parameter logic [32:0] MAX_PAGES             = 33'd65536,
  parameter logic [31:0] TIMEOUT_CYCLES        = 32'd2000000000,
  parameter bit          VERIFY_EN             = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] page_addr,
  input  logic [31:0] page_count,
  output logic        host_rd,
  input  logic [7:0]  host_din,
  output logic        rb_valid,
  output logic [7:0]  rb_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] wr_sum,
  output logic [31:0] rd_sum,
  output logic [3:0]  state_dbg,
  flash_program_seq_if.master fl
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CHECK  = 4'd1;
  localparam logic [3:0] S_ERASE  = 4'd2;
  localparam logic [3:0] S_EWAIT  = 4'd3;
  localparam logic [3:0] S_WRITE  = 4'd4;
  localparam logic [3:0] S_WWAIT  = 4'd5;
  localparam logic [3:0] S_VERIFY = 4'd6;
  localparam logic [3:0] S_VWAIT  = 4'd7;
  localparam logic [3:0] S_FIN    = 4'd8;

  logic [3:0]  state;
  logic [3:0]  wait_next;
  logic [31:0] addr_q;
  logic [31:0] count_q;
  logic [31:0] tcnt;
  logic        rd_pend;
  logic [31:0] first_s;
  logic [31:0] last_s;
  logic [32:0] job_end;
  logic        timed_out;

  assign host_rd   = fl.fl_rd;
  assign fl.fl_din = host_din;
  assign state_dbg = state;

  assign first_s   = addr_q >> PAGES_LOG2_PER_SECTOR;
  assign last_s    = (addr_q + count_q - 32'd1) >> PAGES_LOG2_PER_SECTOR;
  // 33-bit sum so an address near 2^32 cannot wrap past the range check
  assign job_end   = {1'b0, addr_q} + {1'b0, count_q};
  assign timed_out = (TIMEOUT_CYCLES != 32'd0) && (tcnt == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    wait_next = S_FIN;
    case (state)
      S_EWAIT: wait_next = S_WRITE;
      S_WWAIT: wait_next = VERIFY_EN ? S_VERIFY : S_FIN;
      default: wait_next = S_FIN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      count_q        <= '0;
      tcnt           <= '0;
      rd_pend        <= 1'b0;
      rb_valid       <= 1'b0;
      rb_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= '0;
      wr_sum         <= '0;
      rd_sum         <= '0;
      fl.fl_erase    <= 1'b0;
      fl.fl_write    <= 1'b0;
      fl.fl_read_cmd <= 1'b0;
      fl.fl_addr     <= '0;
      fl.fl_length   <= '0;
    end else begin
      fl.fl_erase    <= 1'b0;
      fl.fl_write    <= 1'b0;
      fl.fl_read_cmd <= 1'b0;
      done           <= 1'b0;

      // host byte is valid the cycle after the fl_rd strobe
      rd_pend <= fl.fl_rd;
      if (rd_pend) wr_sum <= wr_sum + {24'd0, host_din};

      rb_valid <= fl.fl_wr;
      if (fl.fl_wr) begin
        rb_data <= fl.fl_dout;
        rd_sum  <= rd_sum + {24'd0, fl.fl_dout};
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q  <= page_addr;
            count_q <= page_count;
            err     <= 2'd0;
            wr_sum  <= '0;
            rd_sum  <= '0;
            busy    <= 1'b1;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (count_q == 32'd0 || job_end > MAX_PAGES) begin
            err   <= 2'd1;
            state <= S_FIN;
          end else begin
            state <= S_ERASE;
          end
        end
        S_ERASE: begin
          fl.fl_addr   <= first_s;
          fl.fl_length <= last_s - first_s + 32'd1;
          fl.fl_erase  <= 1'b1;
          tcnt         <= '0;
          state        <= S_EWAIT;
        end
        S_WRITE: begin
          fl.fl_addr   <= addr_q;
          fl.fl_length <= count_q - 32'd1;
          fl.fl_write  <= 1'b1;
          tcnt         <= '0;
          state        <= S_WWAIT;
        end
        S_VERIFY: begin
          fl.fl_addr     <= addr_q;
          fl.fl_length   <= count_q - 32'd1;
          fl.fl_read_cmd <= 1'b1;
          tcnt           <= '0;
          state          <= S_VWAIT;
        end
        S_EWAIT, S_WWAIT, S_VWAIT: begin
          if (fl.fl_done) begin
            state <= wait_next;
          end else if (timed_out) begin
            // flash_b is abandoned mid-operation; caller must reset before reuse
            err   <= 2'd2;
            state <= S_FIN;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        S_FIN: begin
          if (VERIFY_EN && err == 2'd0 && wr_sum != rd_sum) err <= 2'd3;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
